// File: rtl/inert_spi_resp.sv
// SPI-slave model of an inertial sensor: a small config register map, a sampled
// pitch-rate/Z-accel snapshot, and a data-ready interrupt driven by an ODR divider.
module inert_spi_resp #(
   parameter logic [17:0] ODR_DIV = 18'd240385,
   parameter logic [7:0]  WHOAMI  = 8'h6A
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        SS_n,
   input  logic        SCLK,
   input  logic        MOSI,
   output logic        MISO,
   output logic        INT,
   input  logic [15:0] ptch_rt_in,
   input  logic [15:0] az_in
);

   logic        r_ss_s1, r_ss_s2, r_ss_s3;
   logic        r_sclk_s1, r_sclk_s2, r_sclk_s3;
   logic        r_mosi_s1, r_mosi_s2;
   logic [1:0]  r_rdy;
   logic        r_armed, r_in_frame;
   logic [4:0]  r_cnt;
   logic [15:0] r_rx;
   logic [7:0]  r_rd_byte;
   logic        r_miso, r_int, r_pend;
   logic [7:0]  r_int1, r_ctrl1, r_ctrl2, r_ctrl5;
   logic [15:0] r_ptch, r_az;
   logic [17:0] r_odr;

   logic        w_ss_fall, w_ss_rise, w_sclk_rise, w_sclk_fall;
   logic        w_end, w_full, w_wr, w_clr;
   logic        w_hdr_rd;
   logic [6:0]  w_hdr_addr;
   logic [7:0]  w_rd_val;
   logic        w_odr_en, w_tick, w_snap;

   assign w_ss_fall   =  r_ss_s3 & ~r_ss_s2;
   assign w_ss_rise   = ~r_ss_s3 &  r_ss_s2;
   assign w_sclk_rise = ~r_sclk_s3 &  r_sclk_s2;
   assign w_sclk_fall =  r_sclk_s3 & ~r_sclk_s2;

   // Header as it will stand after the 8th rise's shift completes.
   assign w_hdr_rd   = r_rx[6];
   assign w_hdr_addr = {r_rx[5:0], r_mosi_s2};

   assign w_end  = r_in_frame & w_ss_rise;
   assign w_full = (r_cnt == 5'd16);
   assign w_wr   = w_end & w_full & ~r_rx[15];
   assign w_clr  = w_end & w_full &  r_rx[15] & (r_rx[14:8] == 7'h2D);

   assign w_odr_en = r_int1[1] & (r_ctrl2 != 8'h00);
   assign w_tick   = w_odr_en & (r_odr == ODR_DIV - 18'd1);
   assign w_snap   = (w_tick | r_pend) & ~r_in_frame;

   assign MISO = r_miso;
   assign INT  = r_int;

   always_comb begin
      w_rd_val = 8'h00;
      case (w_hdr_addr)
         7'h0D:   w_rd_val = r_int1;
         7'h0F:   w_rd_val = WHOAMI;
         7'h10:   w_rd_val = r_ctrl1;
         7'h11:   w_rd_val = r_ctrl2;
         7'h14:   w_rd_val = r_ctrl5;
         7'h22:   w_rd_val = r_ptch[7:0];
         7'h23:   w_rd_val = r_ptch[15:8];
         7'h2C:   w_rd_val = r_az[7:0];
         7'h2D:   w_rd_val = r_az[15:8];
         default: w_rd_val = 8'h00;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         {r_ss_s1, r_ss_s2, r_ss_s3}       <= 3'b111;
         {r_sclk_s1, r_sclk_s2, r_sclk_s3} <= 3'b111;
         {r_mosi_s1, r_mosi_s2}            <= 2'b00;
      end else begin
         {r_ss_s1, r_ss_s2, r_ss_s3}       <= {SS_n, r_ss_s1, r_ss_s2};
         {r_sclk_s1, r_sclk_s2, r_sclk_s3} <= {SCLK, r_sclk_s1, r_sclk_s2};
         {r_mosi_s1, r_mosi_s2}            <= {MOSI, r_mosi_s1};
      end
   end

   // r_rdy lets the sync chain flush so r_armed sees the real pin, not the reset value.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_rdy      <= 2'b00;
         r_armed    <= 1'b0;
         r_in_frame <= 1'b0;
         r_cnt      <= 5'd0;
         r_rx       <= 16'h0000;
         r_rd_byte  <= 8'h00;
         r_miso     <= 1'b0;
      end else begin
         r_rdy <= {r_rdy[0], 1'b1};
         if (r_rdy[1] && r_ss_s2) r_armed <= 1'b1;

         if (w_ss_fall && r_armed && !r_in_frame) begin
            r_in_frame <= 1'b1;
            r_cnt      <= 5'd0;
         end else if (r_in_frame) begin
            if (w_ss_rise) begin
               r_in_frame <= 1'b0;
            end else if (w_sclk_rise) begin
               r_rx <= {r_rx[14:0], r_mosi_s2};
               if (r_cnt != 5'd31) r_cnt <= r_cnt + 5'd1;
               if (r_cnt == 5'd7) r_rd_byte <= w_hdr_rd ? w_rd_val : 8'h00;
            end
         end

         if (!r_in_frame || r_ss_s2)
            r_miso <= 1'b0;
         else if (w_sclk_fall)
            r_miso <= (r_cnt[4:3] == 2'b01) ? r_rd_byte[~r_cnt[2:0]] : 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_int1  <= 8'h00;
         r_ctrl1 <= 8'h00;
         r_ctrl2 <= 8'h00;
         r_ctrl5 <= 8'h00;
      end else if (w_wr) begin
         case (r_rx[14:8])
            7'h0D:   r_int1  <= r_rx[7:0];
            7'h10:   r_ctrl1 <= r_rx[7:0];
            7'h11:   r_ctrl2 <= r_rx[7:0];
            7'h14:   r_ctrl5 <= r_rx[7:0];
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst || !w_odr_en)
         r_odr <= 18'd0;
      else if (w_tick)
         r_odr <= 18'd0;
      else
         r_odr <= r_odr + 18'd1;
   end

   // Snapshots never land mid-frame so a read sees a coherent old sample.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_int  <= 1'b0;
         r_pend <= 1'b0;
         r_ptch <= 16'h0000;
         r_az   <= 16'h0000;
      end else if (!r_int1[1]) begin
         r_int  <= 1'b0;
         r_pend <= 1'b0;
      end else if (w_snap) begin
         r_ptch <= ptch_rt_in;
         r_az   <= az_in;
         r_pend <= 1'b0;
         r_int  <= 1'b1;
      end else begin
         if (w_tick) r_pend <= 1'b1;
         if (w_clr)  r_int  <= 1'b0;
      end
   end

endmodule

// File: tb/tb_inert_spi_resp.sv
// Bench for inert_spi_resp: bit-banged SPI master, register-map reference model,
// randomized traffic followed by directed ODR/interrupt/reset scenarios.
module tb_inert_spi_resp;

   localparam int H = 6;

   logic        clk = 1'b0;
   logic        rst, SS_n, SCLK, MOSI, MISO, INT;
   logic [15:0] ptch, az;
   int          cyc = 0;
   int          n_chk = 0;
   int          n_fail = 0;
   logic [7:0]  mdl [0:127];

   inert_spi_resp #(.ODR_DIV(18'd1000), .WHOAMI(8'h6A)) dut (
      .clk(clk), .rst(rst), .SS_n(SS_n), .SCLK(SCLK), .MOSI(MOSI),
      .MISO(MISO), .INT(INT), .ptch_rt_in(ptch), .az_in(az)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic clks(input int n);
      repeat (n) @(negedge clk);
   endtask

   function automatic logic [7:0] mread(input logic [6:0] a);
      return (a == 7'h0F) ? 8'h6A : mdl[a];
   endfunction

   task automatic mwrite(input logic [6:0] a, input logic [7:0] d);
      if (a inside {7'h0D, 7'h10, 7'h11, 7'h14}) mdl[a] = d;
   endtask

   task automatic mclear();
      for (int i = 0; i < 128; i++) mdl[i] = 8'h00;
   endtask

   // MISO is sampled just before each rise; MOSI changes on each fall.
   task automatic frame(input logic [15:0] tx, input int nr,
                        output logic [15:0] rx, output logic int_pre);
      rx = 16'h0000;
      @(negedge clk);
      SS_n = 1'b0;
      clks(H);
      for (int k = 0; k < nr; k++) begin
         SCLK = 1'b0;
         MOSI = (k < 16) ? tx[15-k] : 1'b0;
         clks(H);
         if (k < 16) rx[15-k] = MISO;
         SCLK = 1'b1;
         clks(H);
      end
      int_pre = INT;
      SS_n = 1'b1;
      clks(H);
   endtask

   task automatic xact(input logic [15:0] tx, input int nr, input string tag);
      logic [15:0] rx;
      logic        ip;
      frame(tx, nr, rx, ip);
      if (nr == 16 && !tx[15]) mwrite(tx[14:8], tx[7:0]);
      if (tx[15] && nr >= 16) chk(tag, {8'h00, rx[7:0]}, {8'h00, mread(tx[14:8])});
      chk({tag, "_miso_idle"}, {15'h0, MISO}, 16'h0000);
   endtask

   initial begin
      logic [6:0]  lst [0:8];
      logic [6:0]  a;
      logic [7:0]  d;
      logic [15:0] rx, txw;
      logic        ip;
      int          nr, t, t0;

      lst = '{7'h0D, 7'h10, 7'h11, 7'h14, 7'h0F, 7'h22, 7'h23, 7'h2C, 7'h2D};
      rst = 1'b1; SS_n = 1'b1; SCLK = 1'b1; MOSI = 1'b0; ptch = 16'h0; az = 16'h0;
      mclear();
      clks(4);
      chk("rst_miso", {15'h0, MISO}, 16'h0000);
      chk("rst_int",  {15'h0, INT},  16'h0000);
      rst = 1'b0;
      clks(4);
      xact(16'h8F00, 16, "whoami_first");

      // Random traffic with the data-ready path kept disabled.
      for (int i = 0; i < 24; i++) begin
         a  = ($urandom_range(0, 9) == 9) ? 7'($urandom) : lst[$urandom_range(0, 8)];
         d  = 8'($urandom);
         if (a == 7'h0D) d[1] = 1'b0;
         nr = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 20) : 16;
         xact({1'($urandom), a, d}, nr, "rand");
      end

      rst = 1'b1;
      clks(3);
      chk("rst2_miso", {15'h0, MISO}, 16'h0000);
      chk("rst2_int",  {15'h0, INT},  16'h0000);
      rst = 1'b0;
      mclear();
      clks(4);
      xact(16'h9000, 16, "rst2_ctrl1");
      xact(16'h9100, 16, "rst2_ctrl2");

      xact(16'h0D02, 16, "w_int1");
      xact(16'h8D00, 16, "r_int1");
      xact(16'h8F00, 16, "r_whoami");
      xact(16'h0F55, 16, "w_whoami_ro");
      xact(16'h8F00, 16, "r_whoami_ro");
      xact(16'h8700, 16, "r_unmapped");
      xact(16'h1053, 12, "w_abort");
      xact(16'h9000, 16, "r_abort");

      ptch = 16'h1234; az = 16'hFEDC;
      xact(16'h1150, 16, "w_ctrl2");
      t = 0;
      while (!INT && t < 1100) begin
         @(negedge clk);
         t++;
      end
      t0 = cyc;
      chk("int_latency_ok", {15'h0, (t >= 980 && t <= 1001)}, 16'h0001);
      mdl[7'h22] = 8'h34; mdl[7'h23] = 8'h12; mdl[7'h2C] = 8'hDC; mdl[7'h2D] = 8'hFE;
      xact(16'hA200, 16, "r_ptch_lo");
      xact(16'hA300, 16, "r_ptch_hi");
      xact(16'hAC00, 16, "r_az_lo");
      frame(16'hAD00, 16, rx, ip);
      chk("r_az_hi", {8'h00, rx[7:0]}, 16'h00FE);
      chk("int_before_clr", {15'h0, ip}, 16'h0001);
      chk("int_after_clr", {15'h0, INT}, 16'h0000);

      while (cyc < t0 + 1010) @(negedge clk);
      chk("int_next_tick", {15'h0, INT}, 16'h0001);
      ptch = 16'hBEEF; az = 16'hCAFE;
      frame(16'hAD00, 16, rx, ip);
      chk("r_az_hi2", {8'h00, rx[7:0]}, 16'h00FE);
      chk("int_after_clr2", {15'h0, INT}, 16'h0000);
      while (cyc < t0 + 1900) @(negedge clk);
      frame(16'hA200, 16, rx, ip);
      chk("r_ptch_old_midtick", {8'h00, rx[7:0]}, 16'h0034);
      chk("int_held_in_frame", {15'h0, ip}, 16'h0000);
      chk("int_after_pend", {15'h0, INT}, 16'h0001);
      mdl[7'h22] = 8'hEF; mdl[7'h23] = 8'hBE; mdl[7'h2C] = 8'hFE; mdl[7'h2D] = 8'hCA;
      xact(16'hA200, 16, "r_ptch_new_lo");
      xact(16'hA300, 16, "r_ptch_new_hi");
      xact(16'hAC00, 16, "r_az_new_lo");

      // Reset in the middle of a frame, then a full write while SS_n stays low.
      @(negedge clk);
      SS_n = 1'b0;
      clks(H);
      txw = 16'h8D00;
      for (int k = 0; k < 5; k++) begin
         SCLK = 1'b0; MOSI = txw[15-k]; clks(H);
         SCLK = 1'b1; clks(H);
      end
      rst = 1'b1;
      clks(2);
      chk("midrst_int",  {15'h0, INT},  16'h0000);
      chk("midrst_miso", {15'h0, MISO}, 16'h0000);
      rst = 1'b0;
      mclear();
      clks(2);
      txw = 16'h1077;
      for (int k = 0; k < 16; k++) begin
         SCLK = 1'b0; MOSI = txw[15-k]; clks(H);
         SCLK = 1'b1; clks(H);
      end
      SS_n = 1'b1;
      clks(H);
      chk("postrst_int", {15'h0, INT}, 16'h0000);
      xact(16'h8D00, 16, "postrst_int1");
      xact(16'h9000, 16, "postrst_noarm");
      xact(16'hA200, 16, "postrst_snap");
      xact(16'h0D02, 16, "postrst_w_int1");
      xact(16'h8D00, 16, "postrst_r_int1");
      chk("final_int", {15'h0, INT}, 16'h0000);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
